// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin arbiter and packet router for the shared driver bus.
// Grants one pending FIFO at a time, pops its head packet, then pushes the packet
// to the destination named in its top byte. Unaddressable packets are dropped
// and counted in a saturating counter.
// Optional feature: define BUS_ARB_BCAST_EN to deliver packets addressed to
// `bcast` to every driver except the source.
module bus_rr_arbiter #(
    parameter int unsigned drvrs   = 4,
    parameter int unsigned pckg_sz = 16,
    parameter logic [7:0]  bcast   = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [pckg_sz-1:0]         D_push,
    output logic [3:0]                 gnt_id,
    output logic                       busy,
    output logic [7:0]                 drop_cnt
);

`ifdef BUS_ARB_BCAST_EN
    localparam bit BcastEn = 1'b1;
`else
    localparam bit BcastEn = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

    state_t               state_q, state_d;
    logic [3:0]           rr_q, rr_d;
    logic [3:0]           gnt_q, gnt_d;
    logic [3:0]           pick;
    logic                 found;
    int unsigned          cand;
    logic [pckg_sz-1:0]   slice;
    logic [pckg_sz-1:0]   pkt_q, pkt_d;
    logic [7:0]           dest;
    logic                 is_bcast, is_valid;
    logic [7:0]           drop_q, drop_d;
    logic [drvrs-1:0]     pop_q, pop_d;
    logic [drvrs-1:0]     push_q, push_d;
    logic                 busy_q, busy_d;

    // Round-robin pick: first pending requester at or after rr_q, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = 0;
        for (int unsigned k = 0; k < drvrs; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= drvrs) cand = cand - drvrs;
            for (int unsigned j = 0; j < drvrs; j++) begin
                if (!found && pndng[j] && (cand == j)) begin
                    found = 1'b1;
                    pick  = 4'(j);
                end
            end
        end
    end

    // Head packet of the granted driver and classification of its destination.
    always_comb begin
        slice = '0;
        for (int unsigned i = 0; i < drvrs; i++) begin
            if (gnt_q == 4'(i)) slice = D_pop[i*pckg_sz +: pckg_sz];
        end
        dest     = slice[pckg_sz-1 -: 8];
        is_bcast = BcastEn && (dest == bcast);
        is_valid = (dest < 8'(drvrs)) && (dest != {4'b0000, gnt_q});
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: IDLE waits for a request, POP and PUSH each last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (found) state_d = POP;
            POP:     state_d = PUSH;
            PUSH:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; the push decision is made while the
    // packet is captured so that push and D_push appear together.
    always_comb begin
        pop_d  = '0;
        push_d = '0;
        gnt_d  = gnt_q;
        rr_d   = rr_q;
        pkt_d  = pkt_q;
        drop_d = drop_q;
        busy_d = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d = pick;
                    for (int unsigned j = 0; j < drvrs; j++) begin
                        pop_d[j] = (pick == 4'(j));
                    end
                end
            end
            POP: begin
                pkt_d = slice;
                rr_d  = ((32'(gnt_q) + 32'd1) >= drvrs) ? '0 : gnt_q + 4'd1;
                if (is_bcast) begin
                    for (int unsigned j = 0; j < drvrs; j++) begin
                        push_d[j] = (gnt_q != 4'(j));
                    end
                end else if (is_valid) begin
                    for (int unsigned j = 0; j < drvrs; j++) begin
                        push_d[j] = (dest == 8'(j));
                    end
                end else if (drop_q != 8'hFF) begin
                    drop_d = drop_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pop_q  <= '0;
            push_q <= '0;
            gnt_q  <= '0;
            rr_q   <= '0;
            pkt_q  <= '0;
            drop_q <= '0;
            busy_q <= 1'b0;
        end else begin
            pop_q  <= pop_d;
            push_q <= push_d;
            gnt_q  <= gnt_d;
            rr_q   <= rr_d;
            pkt_q  <= pkt_d;
            drop_q <= drop_d;
            busy_q <= busy_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = pkt_q;
    assign gnt_id   = gnt_q;
    assign busy     = busy_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Testbench for bus_rr_arbiter (4 drivers, 16-bit packets, broadcast ID 8'hFF).
// Expectations for broadcast packets follow BUS_ARB_BCAST_EN.
module tb_bus_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [15:0] D_push;
    logic [3:0]  gnt_id;
    logic        busy;
    logic [7:0]  drop_cnt;

    int n_total = 0;
    int n_pass  = 0;

`ifdef BUS_ARB_BCAST_EN
    localparam logic [3:0] BC_PUSH = 4'b1011;
    localparam int         BC_DROP = 0;
`else
    localparam logic [3:0] BC_PUSH = 4'b0000;
    localparam int         BC_DROP = 1;
`endif

    bus_rr_arbiter #(.drvrs(4), .pckg_sz(16), .bcast(8'hFF)) dut (
        .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
        .pop(pop), .push(push), .D_push(D_push), .gnt_id(gnt_id),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  pndng;
        logic [63:0] dpop;
        logic [3:0]  gnt;
        logic [3:0]  push;
        logic [15:0] dpush;
        logic [7:0]  drop;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(logic [3:0] p, logic [63:0] dp, logic [3:0] g,
                                logic [3:0] pu, logic [15:0] dpu, logic [7:0] dr);
        vec_t v;
        v.pndng = p; v.dpop = dp; v.gnt = g; v.push = pu; v.dpush = dpu; v.drop = dr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: grant = pending bit with smallest cyclic distance from rr.
    int m_rr;
    int m_drop;

    function automatic int m_grant(logic [3:0] p, int rr);
        int best = 0;
        int bestd = 99;
        int d;
        for (int i = 0; i < 4; i++) begin
            d = (i - rr + 4) % 4;
            if (p[i] && d < bestd) begin
                bestd = d;
                best  = i;
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] m_push(logic [7:0] dest, int g);
`ifdef BUS_ARB_BCAST_EN
        if (dest == 8'hFF) return 4'b1111 & ~(4'b0001 << g);
`endif
        if (dest < 8'd4 && int'(dest) != g) return 4'b0001 << dest;
        return 4'b0000;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        pndng = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        m_rr = 0;
        m_drop = 0;
    endtask

    // One transfer starting from IDLE: E0 pop, E1 push, E2 back in IDLE.
    task automatic do_txn(input string nm, input logic [3:0] p, input logic [63:0] dp,
                          input logic [3:0] eg, input logic [3:0] epush,
                          input logic [15:0] edp, input logic [7:0] edrop);
        pndng = p;
        D_pop = dp;
        @(posedge clk); #1;
        chk({nm, ".pop"}, 64'(pop), 64'(4'b0001 << eg));
        chk({nm, ".gnt"}, 64'(gnt_id), 64'(eg));
        chk({nm, ".busy0"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({nm, ".pop1"}, 64'(pop), 64'd0);
        chk({nm, ".push"}, 64'(push), 64'(epush));
        chk({nm, ".dpush"}, 64'(D_push), 64'(edp));
        chk({nm, ".busy1"}, 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk({nm, ".push2"}, 64'(push), 64'd0);
        chk({nm, ".busy2"}, 64'(busy), 64'd0);
        chk({nm, ".hold"}, 64'(D_push), 64'(edp));
        chk({nm, ".drop"}, 64'(drop_cnt), 64'(edrop));
        pndng = '0;
    endtask

    initial begin
        logic [3:0]  p;
        logic [63:0] dp;
        logic [7:0]  dst;
        logic [3:0]  ep;
        int          g;
        int          npops;

        reset = 1'b0;
        pndng = '0;
        D_pop = '0;

        // Reset held with all requests pending: every output stays 0.
        pndng = 4'b1111;
        D_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0100};
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("rst.pop", 64'(pop), 64'd0);
            chk("rst.push", 64'(push), 64'd0);
            chk("rst.busy", 64'(busy), 64'd0);
            chk("rst.drop", 64'(drop_cnt), 64'd0);
            chk("rst.gnt", 64'(gnt_id), 64'd0);
        end
        reset = 1'b1;
        do_txn("rst.first", 4'b1111, {16'h0000, 16'h0000, 16'h0000, 16'h0100},
               4'd0, 4'b0010, 16'h0100, 8'd0);

        // Directed table, applied back to back from a fresh reset.
        vecs[0] = mk(4'b0010, {16'h0000, 16'h0000, 16'h03A5, 16'h0000}, 4'd1, 4'b1000, 16'h03A5, 8'd0);
        vecs[1] = mk(4'b1111, {16'h0003, 16'h0302, 16'h0201, 16'h0100}, 4'd2, 4'b1000, 16'h0302, 8'd0);
        vecs[2] = mk(4'b1111, {16'h0003, 16'h0302, 16'h0201, 16'h0100}, 4'd3, 4'b0001, 16'h0003, 8'd0);
        vecs[3] = mk(4'b1111, {16'h0003, 16'h0302, 16'h0201, 16'h0100}, 4'd0, 4'b0010, 16'h0100, 8'd0);
        vecs[4] = mk(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h07AB}, 4'd0, 4'b0000, 16'h07AB, 8'd1);
        vecs[5] = mk(4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0012}, 4'd0, 4'b0000, 16'h0012, 8'd2);
        vecs[6] = mk(4'b0100, {16'h0000, 16'hFF11, 16'h0000, 16'h0000}, 4'd2, BC_PUSH, 16'hFF11, 8'(2 + BC_DROP));
        vecs[7] = mk(4'b1001, {16'h0166, 16'h0000, 16'h0000, 16'h0255}, 4'd3, 4'b0010, 16'h0166, 8'(2 + BC_DROP));
        vecs[8] = mk(4'b1001, {16'h0166, 16'h0000, 16'h0000, 16'h0255}, 4'd0, 4'b0100, 16'h0255, 8'(2 + BC_DROP));
        vecs[9] = mk(4'b0110, {16'h0000, 16'h0000, 16'h0499, 16'h0000}, 4'd1, 4'b0000, 16'h0499, 8'(3 + BC_DROP));
        do_reset();
        for (int i = 0; i < 10; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].pndng, vecs[i].dpop, vecs[i].gnt,
                   vecs[i].push, vecs[i].dpush, vecs[i].drop);
        end

        // Fairness: all requests held for 12 cycles, one grant every 3 cycles in order.
        do_reset();
        pndng = 4'b1111;
        D_pop = {16'h0000, 16'h0300, 16'h0200, 16'h0100};
        npops = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (pop != 4'b0000) npops++;
            chk($sformatf("rr.pop%0d", e), 64'(pop), (e % 3 == 0) ? 64'(4'b0001 << (e / 3)) : 64'd0);
            if (e % 3 == 0) chk($sformatf("rr.gnt%0d", e), 64'(gnt_id), 64'(e / 3));
            if (e % 3 == 1) chk($sformatf("rr.push%0d", e), 64'(push), 64'(4'b0001 << ((e / 3 + 1) % 4)));
        end
        pndng = '0;
        chk("rr.npops", 64'(npops), 64'd4);

        // Drop counter saturation: 300 consecutive unaddressable packets.
        do_reset();
        pndng = 4'b0001;
        D_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0700};
        for (int e = 0; e < 900; e++) begin
            @(posedge clk); #1;
            if (e == 761) chk("sat.254", 64'(drop_cnt), 64'd254);
            if (e == 764) chk("sat.255", 64'(drop_cnt), 64'd255);
        end
        pndng = '0;
        repeat (3) @(posedge clk);
        #1 chk("sat.final", 64'(drop_cnt), 64'd255);

        // Reset during the PUSH cycle: packet is discarded and not re-delivered.
        do_reset();
        pndng = 4'b0010;
        D_pop = {16'h0000, 16'h0000, 16'h03A5, 16'h0000};
        @(posedge clk); #1;
        chk("mid.pop", 64'(pop), 64'b0010);
        pndng = '0;
        @(posedge clk); #1;
        chk("mid.push", 64'(push), 64'b1000);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid.push_after", 64'(push), 64'd0);
        chk("mid.busy", 64'(busy), 64'd0);
        chk("mid.dpush", 64'(D_push), 64'd0);
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mid.no_redeliver", 64'({pop, push}), 64'd0);
        end

        // Randomized transfers checked against the reference model.
        do_reset();
        for (int t = 0; t < 200; t++) begin
            p  = 4'($urandom_range(1, 15));
            dp = '0;
            for (int i = 0; i < 4; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: dst = 8'($urandom_range(0, 3));
                    6:                dst = 8'hFF;
                    7:                dst = 8'h07;
                    default:          dst = 8'($urandom_range(4, 254));
                endcase
                dp[i*16 +: 16] = {dst, 8'($urandom)};
            end
            g   = m_grant(p, m_rr);
            dst = dp[g*16 + 8 +: 8];
            ep  = m_push(dst, g);
            if (ep == 4'b0000 && m_drop < 255) m_drop++;
            m_rr = (g + 1) % 4;
            do_txn($sformatf("rnd%0d", t), p, dp, 4'(g), ep, dp[g*16 +: 16], 8'(m_drop));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
